// File: rtl/crosshair_overlay_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_if
// Description : VGA timing and colour bundle passed between draw stages.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/crosshair_overlay.sv
`default_nettype none
// ============================================================================
// Module      : crosshair_overlay
// Description : Plus-shaped crosshair drawn at a frame-latched mouse position,
//               with a fire flash/grow animation, cooldown and shot event.
// Revision    : 1.0 - initial release
// ============================================================================
module crosshair_overlay #(
  parameter int          ARM_LEN      = 7,
  parameter int          LINE_W       = 3,
  parameter int          GAP          = 0,
  parameter int          FLASH_GROW   = 3,
  parameter logic [11:0] COLOR_IDLE   = 12'hFFF,
  parameter logic [11:0] COLOR_FIRE   = 12'hF00,
  parameter int          FLASH_FRAMES = 6,
  parameter int          COOL_FRAMES  = 10,
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        fire,
  input  logic        en,
  vga_if.in           in,
  vga_if.out          out,
  output logic        shot_pulse,
  output logic [11:0] shot_x,
  output logic [11:0] shot_y,
  output logic        busy
);

  // Zero frame counts behave as a single frame
  localparam int FLASH_N = (FLASH_FRAMES < 1) ? 1 : FLASH_FRAMES;
  localparam int COOL_N  = (COOL_FRAMES  < 1) ? 1 : COOL_FRAMES;
  localparam int CNT_MAX = (FLASH_N > COOL_N) ? FLASH_N : COOL_N;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_N - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOL_N - 1);
  localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - 1);
  localparam logic [11:0] X_RST    = 12'(H_ACTIVE / 2);
  localparam logic [11:0] Y_RST    = 12'(V_ACTIVE / 2);
  localparam logic [11:0] HALF_W   = 12'(LINE_W / 2);
  localparam logic [11:0] ARM_IDLE = 12'(ARM_LEN);
  localparam logic [11:0] ARM_FIRE = 12'(ARM_LEN + FLASH_GROW);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLASH    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              vblnk_d;
  logic              fire_d;
  logic [11:0]       cur_x;
  logic [11:0]       cur_y;
  logic              frame_tick;
  logic              fire_edge;

  assign frame_tick = in.vblnk & ~vblnk_d;
  assign fire_edge  = fire & ~fire_d;

  // Edge-detect history and frame-synchronised position latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_d <= 1'b0;
      fire_d  <= 1'b0;
      cur_x   <= X_RST;
      cur_y   <= Y_RST;
    end else begin
      vblnk_d <= in.vblnk;
      fire_d  <= fire;
      if (frame_tick) begin
        cur_x <= (xpos > X_MAX) ? X_MAX : xpos;
        cur_y <= (ypos > Y_MAX) ? Y_MAX : ypos;
      end
    end
  end

  // Fire FSM: one shot per button edge, then frame-counted flash and cooldown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shot_pulse <= 1'b0;
      shot_x     <= '0;
      shot_y     <= '0;
      busy       <= 1'b0;
    end else begin
      shot_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident frame tick is ignored here so the new count stays intact
          if (fire_edge) begin
            state      <= FLASH;
            cnt        <= FLASH_LOAD;
            shot_x     <= cur_x;
            shot_y     <= cur_y;
            shot_pulse <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (cnt == '0) begin
              state <= COOLDOWN;
              cnt   <= COOL_LOAD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Signed offsets so a cursor near an edge never wraps onto the far side
  logic signed [12:0] dx;
  logic signed [12:0] dy;
  logic        [12:0] dx_neg;
  logic        [12:0] dy_neg;

  assign dx     = $signed({1'b0, in.hcount}) - $signed({1'b0, cur_x});
  assign dy     = $signed({1'b0, in.vcount}) - $signed({1'b0, cur_y});
  assign dx_neg = -dx;
  assign dy_neg = -dy;

  logic [11:0] s1_adx, s1_ady, s1_arm, s1_color;
  logic [11:0] s1_hcount, s1_vcount, s1_rgb;
  logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk, s1_en;

  // Stage 1: distances, arm length and colour for the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_adx    <= '0;
      s1_ady    <= '0;
      s1_arm    <= '0;
      s1_color  <= '0;
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_rgb    <= '0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_en     <= 1'b0;
    end else begin
      s1_adx    <= dx[12] ? dx_neg[11:0] : dx[11:0];
      s1_ady    <= dy[12] ? dy_neg[11:0] : dy[11:0];
      s1_arm    <= (state == FLASH) ? ARM_FIRE : ARM_IDLE;
      s1_color  <= (state == FLASH) ? COLOR_FIRE : COLOR_IDLE;
      s1_hcount <= in.hcount;
      s1_vcount <= in.vcount;
      s1_rgb    <= in.rgb;
      s1_hsync  <= in.hsync;
      s1_vsync  <= in.vsync;
      s1_hblnk  <= in.hblnk;
      s1_vblnk  <= in.vblnk;
      s1_en     <= en;
    end
  end

  logic on_h_arm, on_v_arm, in_gap, hit;

  assign on_h_arm = (s1_adx <= s1_arm) && (s1_ady <= HALF_W);
  assign on_v_arm = (s1_ady <= s1_arm) && (s1_adx <= HALF_W);

  generate
    if (GAP > 0) begin : g_gap
      assign in_gap = (s1_adx < 12'(GAP)) && (s1_ady < 12'(GAP));
    end else begin : g_no_gap
      assign in_gap = 1'b0;
    end
  endgenerate

  assign hit = (on_h_arm || on_v_arm) && !in_gap && s1_en && !s1_hblnk && !s1_vblnk;

  // Stage 2: overlay the crosshair colour onto the delayed pixel stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.vsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= s1_hcount;
      out.vcount <= s1_vcount;
      out.hsync  <= s1_hsync;
      out.vsync  <= s1_vsync;
      out.hblnk  <= s1_hblnk;
      out.vblnk  <= s1_vblnk;
      out.rgb    <= hit ? s1_color : s1_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crosshair_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_crosshair_overlay
// Description : Directed self-checking bench for crosshair_overlay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crosshair_overlay;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        fire = 1'b0;
  logic        en = 1'b1;
  logic        sp, sp_g, busy, busy_g;
  logic [11:0] sx, sy, sx_g, sy_g;

  int tests = 0;
  int fails = 0;

  vga_if vin ();
  vga_if vout ();
  vga_if vout_g ();

  crosshair_overlay dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .fire(fire), .en(en),
    .in(vin), .out(vout), .shot_pulse(sp), .shot_x(sx), .shot_y(sy), .busy(busy)
  );

  crosshair_overlay #(.GAP(2)) dut_gap (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .fire(fire), .en(en),
    .in(vin), .out(vout_g), .shot_pulse(sp_g), .shot_x(sx_g), .shot_y(sy_g), .busy(busy_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel and wait out the two-cycle pipeline
  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic [11:0] c);
    @(negedge clk);
    vin.hcount = h;
    vin.vcount = v;
    vin.rgb    = c;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    @(negedge clk);
    vin.vblnk = 1'b1;
    @(negedge clk);
    vin.vblnk = 1'b0;
  endtask

  initial begin
    vin.hcount = 12'd5;
    vin.vcount = 12'd5;
    vin.hsync  = 1'b1;
    vin.vsync  = 1'b1;
    vin.hblnk  = 1'b0;
    vin.vblnk  = 1'b0;
    vin.rgb    = 12'hABC;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rgb", {20'd0, vout.rgb}, 32'h0);
    check("rst_hsync", {31'd0, vout.hsync}, 32'h0);
    check("rst_pulse", {31'd0, sp}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_shot_x", {20'd0, sx}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Crosshair centred after reset
    pix(12'd400, 12'd300, 12'h0AA);
    check("reset_centre", {20'd0, vout.rgb}, 32'hFFF);
    check("gap_centre", {20'd0, vout_g.rgb}, 32'h0AA);
    check("hsync_pass", {31'd0, vout.hsync}, 32'h1);
    pix(12'd407, 12'd301, 12'h0AA);
    check("arm_end", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd408, 12'd300, 12'h0AA);
    check("past_arm", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd402, 12'd302, 12'h0AA);
    check("off_line", {20'd0, vout.rgb}, 32'h0AA);
    @(negedge clk);
    vin.hcount = 12'd400; vin.vcount = 12'd300; vin.rgb = 12'h0AA; vin.hblnk = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("hblnk_pass", {20'd0, vout.rgb}, 32'h0AA);

    // Position only moves on a frame tick
    xpos = 12'd100; ypos = 12'd50;
    pix(12'd100, 12'd50, 12'h0AA);
    check("mid_frame_hold", {20'd0, vout.rgb}, 32'h0AA);
    frame_tick();
    pix(12'd100, 12'd50, 12'h0AA);
    check("moved_centre", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd107, 12'd51, 12'h0AA);
    check("moved_arm", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd108, 12'd50, 12'h0AA);
    check("moved_past", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd102, 12'd52, 12'h0AA);
    check("moved_off", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd101, 12'd51, 12'h0AA);
    check("near_centre", {20'd0, vout.rgb}, 32'hFFF);
    check("gap_inner", {20'd0, vout_g.rgb}, 32'h0AA);
    pix(12'd102, 12'd50, 12'h0AA);
    check("gap_edge", {20'd0, vout_g.rgb}, 32'hFFF);

    // Exact two-cycle latency
    pix(12'd300, 12'd400, 12'h777);
    @(negedge clk);
    vin.rgb = 12'h123;
    @(posedge clk); #1;
    check("lat_1", {20'd0, vout.rgb}, 32'h777);
    @(negedge clk);
    vin.rgb = 12'h456;
    @(posedge clk); #1;
    check("lat_2", {20'd0, vout.rgb}, 32'h123);
    @(posedge clk); #1;
    check("lat_3", {20'd0, vout.rgb}, 32'h456);

    // Top-left corner, no wrap
    xpos = 12'd0; ypos = 12'd0;
    frame_tick();
    pix(12'd0, 12'd0, 12'h0AA);
    check("corner_centre", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd7, 12'd1, 12'h0AA);
    check("corner_arm", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd8, 12'd0, 12'h0AA);
    check("corner_past", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd795, 12'd0, 12'h0AA);
    check("no_wrap_right", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd0, 12'd595, 12'h0AA);
    check("no_wrap_bottom", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd4095, 12'd0, 12'h0AA);
    check("no_wrap_4095", {20'd0, vout.rgb}, 32'h0AA);

    // X clamp
    xpos = 12'd2000; ypos = 12'd50;
    frame_tick();
    pix(12'd799, 12'd50, 12'h0AA);
    check("clamp_centre", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd792, 12'd50, 12'h0AA);
    check("clamp_arm", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd791, 12'd50, 12'h0AA);
    check("clamp_past", {20'd0, vout.rgb}, 32'h0AA);

    // Fire from IDLE
    xpos = 12'd200; ypos = 12'd200;
    frame_tick();
    @(negedge clk);
    fire = 1'b1;
    @(posedge clk); #1;
    check("shot_pulse", {31'd0, sp}, 32'h1);
    check("shot_busy", {31'd0, busy}, 32'h1);
    check("shot_busy_gap", {31'd0, busy_g}, 32'h1);
    check("shot_x", {20'd0, sx}, 32'd200);
    check("shot_y", {20'd0, sy}, 32'd200);
    @(posedge clk); #1;
    check("pulse_one_cycle", {31'd0, sp}, 32'h0);
    @(negedge clk);
    fire = 1'b0;
    pix(12'd210, 12'd200, 12'h0AA);
    check("flash_arm", {20'd0, vout.rgb}, 32'hF00);
    pix(12'd211, 12'd200, 12'h0AA);
    check("flash_past", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd200, 12'd190, 12'h0AA);
    check("flash_v_arm", {20'd0, vout.rgb}, 32'hF00);
    repeat (5) frame_tick();
    pix(12'd210, 12'd200, 12'h0AA);
    check("flash_last", {20'd0, vout.rgb}, 32'hF00);
    frame_tick();
    pix(12'd210, 12'd200, 12'h0AA);
    check("cool_shrunk", {20'd0, vout.rgb}, 32'h0AA);
    pix(12'd207, 12'd200, 12'h0AA);
    check("cool_white", {20'd0, vout.rgb}, 32'hFFF);
    check("cool_busy", {31'd0, busy}, 32'h1);

    // Fire during cooldown is ignored
    @(negedge clk);
    fire = 1'b1;
    @(posedge clk); #1;
    check("cool_no_pulse", {31'd0, sp}, 32'h0);

    // en=0: pass-through while the FSM keeps counting
    en = 1'b0;
    repeat (9) frame_tick();
    check("cool_last", {31'd0, busy}, 32'h1);
    pix(12'd200, 12'd200, 12'h0AA);
    check("en_off", {20'd0, vout.rgb}, 32'h0AA);
    frame_tick();
    check("idle_again", {31'd0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("held_no_refire", {31'd0, busy}, 32'h0);
    en = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    fire = 1'b1;
    @(posedge clk); #1;
    check("refire", {31'd0, sp}, 32'h1);

    // Reset mid-FLASH
    @(negedge clk);
    rst = 1'b0;
    fire = 1'b0;
    #1;
    check("rst2_busy", {31'd0, busy}, 32'h0);
    check("rst2_shot_x", {20'd0, sx}, 32'h0);
    check("rst2_rgb", {20'd0, vout.rgb}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    xpos = 12'd400; ypos = 12'd300;
    pix(12'd400, 12'd300, 12'h0AA);
    check("rst2_centre", {20'd0, vout.rgb}, 32'hFFF);
    pix(12'd410, 12'd300, 12'h0AA);
    check("rst2_idle_arm", {20'd0, vout.rgb}, 32'h0AA);
    check("rst2_idle", {31'd0, busy}, 32'h0);

    // Fire edge coinciding with a frame tick
    @(negedge clk);
    fire = 1'b1;
    vin.vblnk = 1'b1;
    @(posedge clk); #1;
    check("tick_fire_pulse", {31'd0, sp}, 32'h1);
    check("tick_fire_x", {20'd0, sx}, 32'd400);
    @(negedge clk);
    vin.vblnk = 1'b0;
    fire = 1'b0;
    repeat (5) frame_tick();
    pix(12'd410, 12'd300, 12'h0AA);
    check("tick_fire_flash", {20'd0, vout.rgb}, 32'hF00);
    frame_tick();
    pix(12'd410, 12'd300, 12'h0AA);
    check("tick_fire_cool", {20'd0, vout.rgb}, 32'h0AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crosshair_overlay.md
Name: crosshair_overlay

Overview:
- Parametrised crosshair overlay for the VGA pipeline, placed after the background and target draw stages and before the output register stage.
- Draws a plus-shaped crosshair at the mouse position, with configurable arm length, line width, centre gap and colours.
- Position is frame-synchronised (updates only at the start of vblank), so the crosshair never tears mid-frame.
- A fire input triggers a timed flash/grow animation followed by a cooldown, and emits a registered shot event (pulse plus coordinates) for downstream hit detection.

Parameters:
- ARM_LEN, 7, idle half-length of each arm in pixels, excluding the centre pixel.
- LINE_W, 3, arm thickness in pixels; must be odd.
- GAP, 0, half-size of the transparent centre square; 0 means no gap.
- FLASH_GROW, 3, extra pixels added to ARM_LEN while in FLASH.
- COLOR_IDLE, 12'hFFF, crosshair colour in IDLE and COOLDOWN.
- COLOR_FIRE, 12'hF00, crosshair colour in FLASH.
- FLASH_FRAMES, 6, number of frames the FLASH state lasts.
- COOL_FRAMES, 10, number of frames the COOLDOWN state lasts.
- H_ACTIVE, 800, visible width; used for clamping.
- V_ACTIVE, 600, visible height; used for clamping.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- xpos  in  12  mouse X, unsigned.
- ypos  in  12  mouse Y, unsigned.
- fire  in  1  mouse left button, level; synchronous to clk.
- en  in  1  crosshair visible when 1; the FSM runs regardless.
- in  vga_if.in  -  upstream timing (hcount, vcount, hsync, vsync, hblnk, vblnk) plus 12-bit rgb.
- out  vga_if.out  -  same fields, delayed.
- shot_pulse  out  1  single-cycle pulse when a shot is accepted.
- shot_x  out  12  crosshair X captured at the shot.
- shot_y  out  12  crosshair Y captured at the shot.
- busy  out  1  high in FLASH or COOLDOWN.

Behaviour:
- Reset (rst=0, async):
  - All out fields = 0; shot_pulse = 0; shot_x = shot_y = 0; busy = 0.
  - cur_x = H_ACTIVE/2, cur_y = V_ACTIVE/2.
  - FSM = IDLE, frame counter = 0, fire_d = 0, vblnk_d = 0.
- Frame tick: in.vblnk rising edge (in.vblnk=1 and vblnk_d=0), one cycle per frame.
- Position latch, on frame tick only:
  - cur_x = min(xpos, H_ACTIVE-1); cur_y = min(ypos, V_ACTIVE-1).
  - Input changes mid-frame have no effect until the next tick.
- Pixel pipeline: fixed latency of 2 cycles. All timing fields and rgb pass through two register stages.
  - Stage 1 registers: dx = hcount - cur_x and dy = vcount - cur_y, as 13-bit signed; their absolute values; arm = ARM_LEN + (FLASH ? FLASH_GROW : 0); colour select.
  - Stage 2 pixel hit when all of the following hold:
    - (|dx| <= arm and |dy| <= LINE_W/2) or (|dy| <= arm and |dx| <= LINE_W/2);
    - not (|dx| < GAP and |dy| < GAP);
    - en = 1; hblnk = 0; vblnk = 0.
  - On a hit, out.rgb = selected colour; otherwise out.rgb = delayed in.rgb.
  - Signed arithmetic means no wrap: a crosshair at x=0 draws only on columns 0..arm, never at column 4095 or the right edge.
- Fire FSM (fire rising edge = fire & ~fire_d):
  - IDLE: on fire edge, go to FLASH. In the same cycle: counter = FLASH_FRAMES-1; shot_x/shot_y <= cur_x/cur_y; shot_pulse = 1 for the next cycle only.
  - FLASH: on each frame tick, if counter = 0, go to COOLDOWN with counter = COOL_FRAMES-1; otherwise decrement the counter.
  - COOLDOWN: on each frame tick, if counter = 0, go to IDLE; otherwise decrement the counter.
  - Fire edges in FLASH or COOLDOWN are ignored and not queued. A button held through cooldown does not re-fire; a new edge is required.
  - A fire edge and a frame tick in the same cycle while IDLE: the shot is accepted, and the tick does not decrement the new counter.
  - FLASH_FRAMES = 0 or COOL_FRAMES = 0 is treated as 1.
- busy = (state != IDLE), registered.
- shot_x/shot_y hold their value until the next accepted shot.

Test Plan:
- Reset mid-FLASH (rst low for 3 cycles) → all outputs 0 immediately; after release, crosshair at (400,300), IDLE, busy = 0.
- xpos=100, ypos=50 applied mid-frame → frame N unchanged; from frame N+1, pixel (100,50) and (107,51) = FFF, (108,50) = in.rgb, (102,52) = in.rgb; out.rgb delayed exactly 2 cycles.
- xpos=0, ypos=0 → pixels (0..7, 0..1) white; columns 793..799 and rows 593..599 untouched. xpos=2000 → clamped to cur_x = 799.
- fire edge while IDLE with cur = (200,200) → shot_pulse high 1 cycle, shot_x=200, shot_y=200, busy = 1; 6 frames red with arm length 10; then 10 frames white; then busy = 0.
- Second fire edge during COOLDOWN → no shot_pulse, timing unchanged; fire held high across the return to IDLE → no shot until fire goes low then high again.
- GAP=2, en toggling → centre 3x3 pixels pass in.rgb; en=0 → out.rgb equals in.rgb exactly (delayed 2 cycles) while the FSM still advances.
